// File: rtl/cache_assoc.sv
// Set-associative write-back cache with tree-PLRU replacement and a
// line-wide memory port; the CPU side is served combinationally on a hit.
module cache_assoc #(
    parameter int SIZE      = 4*1024*8,
    parameter int LINE_SIZE = 32*8,
    parameter int WAYS      = 2,
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 cache_bus_valid,
    output logic                 cache_bus_ready,
    input  logic [ADDR_SIZE-1:0] cache_bus_addr,
    input  logic                 cache_bus_write,
    input  logic [1:0]           cache_bus_wr_size,
    input  logic [WORD_SIZE-1:0] cache_bus_wr_data,
    output logic [WORD_SIZE-1:0] cache_bus_rd_data,
    output logic                 cache_bus_miss,
    output logic                 memory_bus_valid,
    input  logic                 memory_bus_ready,
    output logic [ADDR_SIZE-1:0] memory_bus_addr,
    output logic                 memory_bus_write,
    output logic [LINE_SIZE-1:0] memory_bus_wr_data,
    input  logic [LINE_SIZE-1:0] memory_bus_rd_data
);
    localparam int SETS   = SIZE / (LINE_SIZE * WAYS);
    localparam int WORDS  = LINE_SIZE / WORD_SIZE;
    localparam int BYTES  = WORD_SIZE / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int WORD_W = $clog2(WORDS);
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_SIZE - SET_W - WORD_W - OFF_W;
    localparam int LOG2W  = $clog2(WAYS);
    localparam int WAY_W  = (WAYS > 1) ? LOG2W : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    typedef enum logic [2:0] {
        READY,
        WRITEBACK_REQUEST,
        WRITEBACK_WAIT,
        FILL_REQUEST,
        FILL_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [SETS-1:0][WAYS-1:0]   dirty_q;
    logic [SETS-1:0][PLRU_W-1:0] plru_q;
    logic [TAG_W-1:0]            tag_q  [SETS][WAYS];
    logic [LINE_SIZE-1:0]        data_q [SETS][WAYS];
    logic [WAY_W-1:0]            victim_q;

    logic [OFF_W-1:0]  byte_off;
    logic [WORD_W-1:0] word_idx;
    logic [SET_W-1:0]  set_idx;
    logic [TAG_W-1:0]  tag_in;

    assign byte_off = cache_bus_addr[OFF_W-1:0];
    assign word_idx = cache_bus_addr[OFF_W +: WORD_W];
    assign set_idx  = cache_bus_addr[OFF_W+WORD_W +: SET_W];
    assign tag_in   = cache_bus_addr[ADDR_SIZE-1 -: TAG_W];

    // Byte lanes come from the low end of wr_data, placed at the addressed offset.
    function automatic logic [LINE_SIZE-1:0] merge_store(
        input logic [LINE_SIZE-1:0] line,
        input logic [WORD_W-1:0]    word,
        input logic [OFF_W-1:0]     off,
        input logic [1:0]           size,
        input logic [WORD_SIZE-1:0] wdata
    );
        logic [LINE_SIZE-1:0] res;
        int base;
        int cnt;
        res = line;
        case (size)
            SZ_BYTE: begin base = int'(off);      cnt = 1;     end
            SZ_HALF: begin base = int'(off) & ~1; cnt = 2;     end
            default: begin base = 0;              cnt = BYTES; end
        endcase
        for (int b = 0; b < BYTES; b++) begin
            if (b >= base && b < base + cnt)
                res[int'(word)*WORD_SIZE + 8*b +: 8] = wdata[8*(b-base) +: 8];
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [PLRU_W-1:0] sh;
        int node;
        int way;
        node = 0;
        way  = 0;
        for (int l = 0; l < LOG2W; l++) begin
            sh   = bits >> node;
            way  = 2*way + (sh[0] ? 1 : 0);
            node = 2*node + 1 + (sh[0] ? 1 : 0);
        end
        return WAY_W'(way);
    endfunction

    // Each node on the path is set to point at the subtree not containing the way.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] res;
        logic [PLRU_W-1:0] mask;
        logic              dir;
        int node;
        res  = bits;
        node = 0;
        for (int l = 0; l < LOG2W; l++) begin
            dir  = ((int'(way) >> (LOG2W-1-l)) & 1) != 0;
            mask = PLRU_W'(1) << node;
            res  = dir ? (res & ~mask) : (res | mask);
            node = 2*node + 1 + (dir ? 1 : 0);
        end
        return res;
    endfunction

    int               hit_cnt;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic             hit;
    logic [WAY_W-1:0] victim;

    always_comb begin
        hit_cnt   = 0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
                hit_cnt = hit_cnt + 1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign hit    = (hit_cnt == 1);
    assign victim = (WAYS == 1) ? '0 :
                    inv_found   ? inv_way : plru_victim(plru_q[set_idx]);

    logic [LINE_SIZE-1:0] hit_line;
    logic [LINE_SIZE-1:0] victim_line;
    logic [ADDR_SIZE-1:0] wb_addr;
    logic                 hit_access;
    logic                 miss_start;
    logic                 wb_done;
    logic                 fill_done;

    assign hit_line          = data_q[set_idx][hit_way];
    assign victim_line       = data_q[set_idx][victim_q];
    assign wb_addr           = {tag_q[set_idx][victim_q], set_idx, {(WORD_W+OFF_W){1'b0}}};
    assign cache_bus_miss    = !hit;
    assign cache_bus_rd_data = hit_line[word_idx*WORD_SIZE +: WORD_SIZE];
    assign cache_bus_ready   = (state_q == READY);

    assign hit_access = (state_q == READY) && cache_bus_valid && hit;
    assign miss_start = (state_q == READY) && cache_bus_valid && !hit && memory_bus_ready;
    assign wb_done    = (state_q == WRITEBACK_WAIT) && memory_bus_ready;
    assign fill_done  = (state_q == FILL_WAIT) && memory_bus_ready;

    always_comb begin
        state_d            = state_q;
        memory_bus_valid   = 1'b0;
        memory_bus_addr    = '0;
        memory_bus_write   = 1'b0;
        memory_bus_wr_data = '0;
        case (state_q)
            READY: begin
                if (miss_start)
                    state_d = dirty_q[set_idx][victim] ? WRITEBACK_REQUEST : FILL_REQUEST;
            end
            WRITEBACK_REQUEST: begin
                memory_bus_valid   = 1'b1;
                memory_bus_addr    = wb_addr;
                memory_bus_write   = 1'b1;
                memory_bus_wr_data = victim_line;
                if (!memory_bus_ready) state_d = WRITEBACK_WAIT;
            end
            WRITEBACK_WAIT: begin
                memory_bus_addr    = wb_addr;
                memory_bus_write   = 1'b1;
                memory_bus_wr_data = victim_line;
                if (memory_bus_ready) state_d = FILL_REQUEST;
            end
            FILL_REQUEST: begin
                memory_bus_valid = 1'b1;
                memory_bus_addr  = cache_bus_addr;
                if (!memory_bus_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                memory_bus_addr = cache_bus_addr;
                if (memory_bus_ready) state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= READY;
            victim_q <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            plru_q   <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start)
                victim_q <= victim;
            if (hit_access && cache_bus_write)
                dirty_q[set_idx][hit_way] <= 1'b1;
            if (hit_access && WAYS > 1)
                plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
            if (wb_done)
                dirty_q[set_idx][victim_q] <= 1'b0;
            if (fill_done) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= cache_bus_write;
                if (WAYS > 1)
                    plru_q[set_idx] <= plru_touch(plru_q[set_idx], victim_q);
            end
        end
    end

    // Line payloads carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (hit_access && cache_bus_write)
            data_q[set_idx][hit_way] <= merge_store(hit_line, word_idx, byte_off,
                                                    cache_bus_wr_size, cache_bus_wr_data);
        if (fill_done) begin
            tag_q[set_idx][victim_q]  <= tag_in;
            data_q[set_idx][victim_q] <= cache_bus_write ?
                merge_store(memory_bus_rd_data, word_idx, byte_off,
                            cache_bus_wr_size, cache_bus_wr_data) :
                memory_bus_rd_data;
        end
    end

endmodule
